// File: rtl/press_classifier.sv
// Classifies button gestures into single click, double click and long press,
// emitting one registered one-cycle pulse per recognised gesture.
module press_classifier #(
    parameter int LONG_CYCLES       = 50_000_000,
    parameter int DOUBLE_WIN_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic debounced,
    input  logic edge_trig,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam int MAX_CYCLES = (LONG_CYCLES > DOUBLE_WIN_CYCLES) ? LONG_CYCLES : DOUBLE_WIN_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(DOUBLE_WIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single_d, double_d, long_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (edge_trig) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                // Release beats the long-press threshold on the same cycle.
                if (!debounced) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT2: begin
                if (edge_trig) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == WIN_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    single_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESS2: begin
                if (!debounced) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end
            end
            HOLD: begin
                if (!debounced) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state and pulse registers use non-blocking assignments so all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            single_click <= single_d;
            double_click <= double_d;
            long_press   <= long_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: stimulus pushes expected pulses with their
// cycle numbers, a negedge monitor pops and compares each pulse the DUT emits.
module tb_press_classifier;

    localparam int LONG = 8;
    localparam int WIN  = 6;
    localparam int K_SINGLE = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_LONG   = 3;

    logic clk = 1'b0;
    logic reset;
    logic debounced;
    logic edge_trig;
    logic single_click;
    logic double_click;
    logic long_press;
    logic busy;

    press_classifier #(
        .LONG_CYCLES      (LONG),
        .DOUBLE_WIN_CYCLES(WIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .debounced   (debounced),
        .edge_trig   (edge_trig),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Cycle n is the period that starts at the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cycle;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step(input logic d, input logic e);
        debounced = d;
        edge_trig = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic expect_pulse(input int kind, input int cycle);
        exp_t e;
        e.kind  = kind;
        e.cycle = cycle;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        int   n;
        n = int'(single_click) + int'(double_click) + int'(long_press);
        if (n != 0) begin
            check("pulse_onehot", n, 1);
            kind = single_click ? K_SINGLE : (double_click ? K_DOUBLE : K_LONG);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", kind, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_cycle", cyc, e.cycle);
            end
        end
    end

    int t0;

    initial begin
        reset     = 1'b1;
        debounced = 1'b0;
        edge_trig = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0);
        check("reset_outputs", {single_click, double_click, long_press, busy}, 4'b0000);
        reset = 1'b0;
        idle(2);

        // Reset in the middle of PRESS1 aborts the gesture silently.
        step(1'b1, 1'b1);
        hold(2);
        check("busy_in_press1", busy, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            check("mid_reset_outputs", {single_click, double_click, long_press, busy}, 4'b0000);
        end
        reset = 1'b0;
        step(1'b1, 1'b0);
        check("busy_after_reset", busy, 1'b0);
        idle(15);

        // Short press: release seen at t0+3, single click at t0+10.
        t0 = cyc;
        expect_pulse(K_SINGLE, t0 + 10);
        step(1'b1, 1'b1);
        hold(2);
        idle(12);
        check("busy_after_single", busy, 1'b0);

        // Double click: second edge 2 cycles after release, second release at t0+25.
        t0 = cyc;
        expect_pulse(K_DOUBLE, t0 + 26);
        step(1'b1, 1'b1);
        hold(2);
        idle(2);
        step(1'b1, 1'b1);
        hold(19);
        idle(10);
        check("busy_after_double", busy, 1'b0);

        // Long press: pulse at t0+9, busy held until the cycle after release.
        t0 = cyc;
        expect_pulse(K_LONG, t0 + 9);
        step(1'b1, 1'b1);
        hold(29);
        check("busy_in_hold", busy, 1'b1);
        step(1'b0, 1'b0);
        check("busy_after_hold_release", busy, 1'b0);
        idle(10);

        // Release on the cycle cnt reaches LONG-1: short press wins.
        t0 = cyc;
        expect_pulse(K_SINGLE, t0 + 15);
        step(1'b1, 1'b1);
        hold(7);
        idle(12);

        // Second edge on the WAIT2 timeout cycle: edge wins, double click at t0+11.
        t0 = cyc;
        expect_pulse(K_DOUBLE, t0 + 11);
        step(1'b1, 1'b1);
        idle(6);
        step(1'b1, 1'b1);
        hold(2);
        idle(10);

        // Edge with debounced low in IDLE still starts a gesture.
        t0 = cyc;
        expect_pulse(K_SINGLE, t0 + 8);
        step(1'b0, 1'b1);
        idle(12);
        check("busy_final", busy, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
